// File: rtl/sonic_ctrl_if.sv
// sonic_ctrl_if: control, echo and read-stage handshake bundle for the ultrasonic sequencer.
interface sonic_if #(parameter int CNT_W = 33);
  logic             i_start;
  logic             i_auto;
  logic             i_echo;
  logic             i_done_read;
  logic             o_trig;
  logic             o_idle;
  logic             o_read;
  logic             o_timeout;
  logic             o_busy;
  logic [CNT_W-1:0] o_echo_cnt;
  modport master (
    output i_start, i_auto, i_echo, i_done_read,
    input  o_trig, o_idle, o_read, o_timeout, o_busy, o_echo_cnt
  );
  modport slave (
    input  i_start, i_auto, i_echo, i_done_read,
    output o_trig, o_idle, o_read, o_timeout, o_busy, o_echo_cnt
  );
endinterface

// File: rtl/sonic_ctrl.sv
// sonic_ctrl: ultrasonic trigger/echo sequencer with echo timeout, hold-off and read-stage handshake.
module sonic_ctrl #(
  parameter int TRIG_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 3800000,
  parameter int HOLDOFF_CYCLES = 6000000,
  parameter int CNT_W          = 33
) (
  input logic    clk,
  input logic    rst_n,
  sonic_if.slave bus
);
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, READ, HOLDOFF} state_t;
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_MAX    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] HO_LAST   = CNT_W'(HOLDOFF_CYCLES - 1);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, echo_cnt_q, echo_cnt_d;
  logic [2:0]       sync_q;
  logic             timeout_q, timeout_d, trig_q, idle_q, read_q, busy_q;
  logic             rise, fall;
  // sync_q = {previous echo_s, echo_s, metastable stage}
  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    echo_cnt_d = echo_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.i_start | bus.i_auto) state_d = TRIG;
      end
      TRIG: if (cnt_q == TRIG_LAST) begin
        state_d = WAIT_RISE;
        cnt_d   = '0;
      end
      WAIT_RISE: if (rise) begin
        state_d = MEASURE;
        cnt_d   = CNT_W'(1);
      end else if (cnt_q == TO_LAST) begin
        state_d   = HOLDOFF;
        cnt_d     = '0;
        timeout_d = 1'b1;
      end
      // echo_s is high throughout MEASURE until the falling edge, so every cycle counts
      MEASURE: if (fall) begin
        state_d    = READ;
        echo_cnt_d = cnt_q;
      end else if (cnt_q == TO_MAX) begin
        state_d   = HOLDOFF;
        cnt_d     = '0;
        timeout_d = 1'b1;
      end
      READ: begin
        cnt_d = '0;
        if (bus.i_done_read) state_d = HOLDOFF;
      end
      HOLDOFF: if (cnt_q == HO_LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      echo_cnt_q <= '0;
      sync_q     <= '0;
      timeout_q  <= 1'b0;
      trig_q     <= 1'b0;
      idle_q     <= 1'b1;
      read_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      echo_cnt_q <= echo_cnt_d;
      sync_q     <= {sync_q[1:0], bus.i_echo};
      timeout_q  <= timeout_d;
      trig_q     <= state_d == TRIG;
      idle_q     <= state_d == IDLE;
      read_q     <= state_d == READ;
      busy_q     <= state_d != IDLE;
    end
  end
  assign bus.o_trig     = trig_q;
  assign bus.o_idle     = idle_q;
  assign bus.o_read     = read_q;
  assign bus.o_timeout  = timeout_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_echo_cnt = echo_cnt_q;
endmodule

// File: tb/tb_sonic_ctrl.sv
// tb_sonic_ctrl: vector table, random echoes against a transaction-level model, and mode/reset sequences.
module tb_sonic_ctrl;
  localparam int TRIG = 4, TO = 50, HO = 20, CNT_W = 33;
  typedef struct {
    int     k;
    int     w;
    int     ack;
    bit     stray;
    bit     exp_to;
    longint exp_cnt;
    int     exp_to_t;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0, errors = 0;
  int tw, to_cnt, to_t, rd_len, h0, idle_t, trig_extra;
  bit saw_read;
  sonic_if #(.CNT_W(CNT_W)) ifc ();
  sonic_ctrl #(.TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TO), .HOLDOFF_CYCLES(HO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  // Outcome of one measurement from the sensor's point of view: echo_s follows i_echo by two
  // synchroniser cycles, so an echo driven k cycles into WAIT_RISE is seen at k+2.
  function automatic void model(input int k, input int w, input longint prev,
                                output bit to, output longint cnt, output int to_t);
    bit seen;
    seen = (w > 0) && (k + 2 < TO);
    to   = !seen || (w > TO);
    cnt  = to ? prev : longint'(w);
    to_t = !seen ? TO : k + 3 + TO;
  endfunction
  task automatic start_pulse();
    @(negedge clk) ifc.i_start = 1'b1;
    @(negedge clk) ifc.i_start = 1'b0;
  endtask
  // Runs one measurement: waits for the trigger, plays the echo, answers the read, stops at IDLE.
  task automatic run(input int k, input int w, input int ack, input bit stray, input int drop);
    int n, t;
    bit rd_now;
    n = 0;
    while (!ifc.o_trig && n < 100) begin @(posedge clk); #1; n++; end
    tw = 0;
    while (ifc.o_trig && tw < 100) begin @(posedge clk); #1; tw++; end
    t = 0; to_cnt = 0; to_t = -1; rd_len = 0; h0 = -1; idle_t = -1; trig_extra = 0; saw_read = 0;
    while (idle_t < 0 && t < 400) begin
      rd_now = ifc.o_read;
      if (rd_now) begin rd_len++; saw_read = 1; end
      if (ifc.o_timeout) begin to_cnt++; to_t = t; end
      if (ifc.o_trig) trig_extra++;
      if (h0 < 0 && (ifc.o_timeout || (saw_read && !rd_now))) h0 = t;
      if (ifc.o_idle) idle_t = t;
      @(negedge clk);
      ifc.i_echo      = (w > 0) && (t >= k) && (t < k + w);
      ifc.i_done_read = rd_now && (rd_len >= ack);
      ifc.i_start     = stray && (t == k + 4);
      if (t == drop) ifc.i_auto = 1'b0;
      @(posedge clk); #1;
      t++;
    end
    ifc.i_echo = 1'b0;
    ifc.i_done_read = 1'b0;
    ifc.i_start = 1'b0;
    if (!ifc.i_auto) begin
      n = 0;
      repeat (5) begin @(posedge clk); #1; if (!ifc.o_idle || ifc.o_trig) n++; end
      chk("stay_idle", n, 0);
    end
  endtask
  task automatic check_run(input string tag, input bit exp_to, input longint exp_cnt,
                           input int exp_to_t, input int ack);
    chk({tag, ".trig_width"}, tw, TRIG);
    chk({tag, ".timeouts"}, to_cnt, exp_to);
    chk({tag, ".read_seen"}, saw_read, !exp_to);
    chk({tag, ".echo_cnt"}, ifc.o_echo_cnt, exp_cnt);
    chk({tag, ".holdoff_len"}, idle_t - h0, HO);
    chk({tag, ".extra_trig"}, trig_extra, 0);
    if (exp_to) chk({tag, ".timeout_at"}, to_t, exp_to_t);
    else chk({tag, ".read_len"}, rd_len, ack);
  endtask
  initial begin
    vec_t   tbl[8];
    bit     e_to;
    longint e_cnt, prev;
    int     e_t, k, w, ack, n;
    tbl[0] = '{7, 12, 3, 0, 0, 12, 0};
    tbl[1] = '{7, 0, 1, 0, 1, 12, 50};
    tbl[2] = '{5, 80, 1, 0, 1, 12, 58};
    tbl[3] = '{3, 50, 1, 0, 0, 50, 0};
    tbl[4] = '{3, 51, 1, 0, 1, 50, 56};
    tbl[5] = '{47, 1, 2, 0, 0, 1, 0};
    tbl[6] = '{48, 5, 1, 0, 1, 1, 50};
    tbl[7] = '{10, 20, 2, 1, 0, 20, 0};
    ifc.i_start = 0; ifc.i_auto = 0; ifc.i_echo = 0; ifc.i_done_read = 0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.idle", ifc.o_idle, 1);
    chk("rst.trig", ifc.o_trig, 0);
    chk("rst.read", ifc.o_read, 0);
    chk("rst.busy", ifc.o_busy, 0);
    chk("rst.timeout", ifc.o_timeout, 0);
    chk("rst.echo_cnt", ifc.o_echo_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      start_pulse();
      run(tbl[i].k, tbl[i].w, tbl[i].ack, tbl[i].stray, -1);
      check_run($sformatf("vec%0d", i), tbl[i].exp_to, tbl[i].exp_cnt, tbl[i].exp_to_t, tbl[i].ack);
    end
    prev = tbl[7].exp_cnt;
    for (int i = 0; i < 8; i++) begin
      k = int'($urandom_range(1, 48));
      w = int'($urandom_range(0, 60));
      ack = int'($urandom_range(1, 4));
      model(k, w, prev, e_to, e_cnt, e_t);
      start_pulse();
      run(k, w, ack, 0, -1);
      check_run($sformatf("rnd%0d_k%0d_w%0d", i, k, w), e_to, e_cnt, e_t, ack);
      prev = e_cnt;
    end
    @(negedge clk) ifc.i_auto = 1'b1;
    run(6, 5, 2, 1, -1);
    check_run("auto1", 0, 5, 0, 2);
    run(6, 9, 2, 0, 11);
    check_run("auto2", 0, 9, 0, 2);
    start_pulse();
    n = 0;
    while (!ifc.o_trig && n < 20) begin @(posedge clk); #1; n++; end
    while (ifc.o_trig && n < 40) begin @(posedge clk); #1; n++; end
    @(negedge clk) ifc.i_echo = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("mid.busy_before_rst", ifc.o_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.idle", ifc.o_idle, 1);
    chk("mid.busy", ifc.o_busy, 0);
    chk("mid.trig", ifc.o_trig, 0);
    chk("mid.read", ifc.o_read, 0);
    chk("mid.timeout", ifc.o_timeout, 0);
    chk("mid.echo_cnt", ifc.o_echo_cnt, 0);
    @(negedge clk) ifc.i_echo = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    start_pulse();
    run(4, 10, 1, 0, -1);
    check_run("after_rst", 0, 10, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
